// File: rtl/smi_pkg.sv
// Shared constants and types for the SMI channel multiplexer.
// A byte with its MSB set is a channel select: {1'b1, 3'b000, ch[3:0]}.
package smi_pkg;

    localparam int         SMI_SEL_BIT  = 7;
    localparam logic [7:0] SMI_SEL_MASK = 8'h80;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_SELECT = 2'd1,
        TX_DATA   = 2'd2
    } tx_state_t;

    function automatic logic [7:0] smi_sel_byte(input logic [3:0] ch);
        return SMI_SEL_MASK | {4'b0000, ch};
    endfunction

endpackage

// File: rtl/smi_rrarb.sv
// Round-robin priority picker: first requester after prev_grant, wrapping,
// with prev_grant itself checked last. Purely combinational.
module smi_rrarb #(
    parameter int NCH  = 4,
    parameter int LGCH = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [LGCH-1:0] prev_grant,
    output logic [LGCH-1:0] next_grant,
    output logic            any_req
);

    logic [LGCH-1:0] idx;
    logic            found;

    always_comb begin
        next_grant = prev_grant;
        found      = 1'b0;
        idx        = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = LGCH'((int'(prev_grant) + i) % NCH);
            if (!found && req[idx]) begin
                next_grant = idx;
                found      = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/smi_chanmux.sv
// Shares one SMI byte link among NCH clients: round-robin TX arbitration with
// channel-select insertion, and select-byte decoding that routes RX data.
module smi_chanmux
    import smi_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int MAXBURST = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NCH-1:0]   S_CH_VALID,
    output logic [NCH-1:0]   S_CH_READY,
    input  logic [7*NCH-1:0] S_CH_DATA,
    output logic             M_TX_VALID,
    input  logic             M_TX_READY,
    output logic [7:0]       M_TX_DATA,
    input  logic             S_RX_VALID,
    output logic             S_RX_READY,
    input  logic [7:0]       S_RX_DATA,
    output logic [NCH-1:0]   M_CH_VALID,
    input  logic [NCH-1:0]   M_CH_READY,
    output logic [6:0]       M_CH_DATA,
    output logic             o_rx_drop,
    output logic [3:0]       o_tx_chan
);

    localparam int LGCH = $clog2(NCH);
    localparam int BW   = $clog2(MAXBURST + 1);

    // Every port pair is AXI-stream style: a byte moves on a rising edge where
    // valid and ready are both high, and the source keeps valid and data stable
    // until then -- except a TX client, which may drop valid to end its grant.

    tx_state_t       tx_state;
    logic [LGCH-1:0] grant;
    logic [LGCH-1:0] last_ch;
    logic            last_vld;
    logic [BW-1:0]   burst;
    logic [LGCH-1:0] rx_ch;
    logic            rx_vld;

    logic [LGCH-1:0] next_grant;
    logic            any_req;
    logic            cur_valid;
    logic [6:0]      cur_payload;
    logic            rx_is_sel;
    logic            rx_sel_ok;

    smi_rrarb #(.NCH(NCH), .LGCH(LGCH)) u_rrarb (
        .req        (S_CH_VALID),
        .prev_grant (grant),
        .next_grant (next_grant),
        .any_req    (any_req)
    );

    assign cur_valid   = S_CH_VALID[grant];
    assign cur_payload = S_CH_DATA[7*int'(grant) +: 7];
    assign rx_is_sel   = S_RX_DATA[SMI_SEL_BIT];
    assign rx_sel_ok   = (S_RX_DATA[6:4] == 3'b000) && ({28'd0, S_RX_DATA[3:0]} < 32'(NCH));
    assign o_tx_chan   = (tx_state == TX_IDLE) ? 4'd0 : 4'(grant);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_state <= TX_IDLE;
            grant    <= LGCH'(NCH - 1);
            last_ch  <= '0;
            last_vld <= 1'b0;
            burst    <= '0;
            rx_ch    <= '0;
            rx_vld   <= 1'b1;
        end else begin
            unique case (tx_state)
                TX_IDLE: begin
                    if (any_req) begin
                        grant    <= next_grant;
                        burst    <= '0;
                        // Skip the select byte when the host already points at this client.
                        tx_state <= (last_vld && last_ch == next_grant) ? TX_DATA : TX_SELECT;
                    end
                end
                TX_SELECT: begin
                    if (M_TX_READY) begin
                        last_ch  <= grant;
                        last_vld <= 1'b1;
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (!cur_valid) begin
                        tx_state <= TX_IDLE;
                    end else if (M_TX_READY) begin
                        burst <= burst + 1'b1;
                        if (burst == BW'(MAXBURST - 1))
                            tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase

            if (S_RX_VALID && rx_is_sel) begin
                rx_vld <= rx_sel_ok;
                if (rx_sel_ok)
                    rx_ch <= LGCH'(S_RX_DATA[3:0]);
            end
        end
    end

    always_comb begin
        M_TX_VALID = 1'b0;
        M_TX_DATA  = 8'h00;
        S_CH_READY = '0;
        if (!i_reset) begin
            unique case (tx_state)
                TX_SELECT: begin
                    M_TX_VALID = 1'b1;
                    M_TX_DATA  = smi_sel_byte(4'(grant));
                end
                TX_DATA: begin
                    M_TX_VALID        = cur_valid;
                    M_TX_DATA         = {1'b0, cur_payload};
                    S_CH_READY[grant] = M_TX_READY;
                end
                default: ;
            endcase
        end
    end

    // Select bytes and orphan data bytes are always accepted; routed data waits on its client.
    always_comb begin
        S_RX_READY = 1'b0;
        M_CH_VALID = '0;
        o_rx_drop  = 1'b0;
        M_CH_DATA  = S_RX_DATA[6:0];
        if (!i_reset) begin
            if (rx_is_sel) begin
                S_RX_READY = 1'b1;
                o_rx_drop  = S_RX_VALID && !rx_sel_ok;
            end else if (rx_vld) begin
                M_CH_VALID[rx_ch] = S_RX_VALID;
                S_RX_READY        = M_CH_READY[rx_ch];
            end else begin
                S_RX_READY = 1'b1;
                o_rx_drop  = S_RX_VALID;
            end
        end
    end

endmodule

// File: tb/tb_smi_chanmux.sv
// Bench for smi_chanmux: directed scenarios plus randomized traffic against a
// stream-level reference (per-client byte queues, select-byte decoding).
module tb_smi_chanmux;

    localparam int NCH      = 4;
    localparam int MAXBURST = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             i_reset;
    logic [NCH-1:0]   s_ch_valid;
    logic [NCH-1:0]   s_ch_ready;
    logic [7*NCH-1:0] s_ch_data;
    logic             m_tx_valid;
    logic             m_tx_ready;
    logic [7:0]       m_tx_data;
    logic             s_rx_valid;
    logic             s_rx_ready;
    logic [7:0]       s_rx_data;
    logic [NCH-1:0]   m_ch_valid;
    logic [NCH-1:0]   m_ch_ready;
    logic [6:0]       m_ch_data;
    logic             o_rx_drop;
    logic [3:0]       o_tx_chan;

    smi_chanmux #(.NCH(NCH), .MAXBURST(MAXBURST)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .S_CH_VALID (s_ch_valid),
        .S_CH_READY (s_ch_ready),
        .S_CH_DATA  (s_ch_data),
        .M_TX_VALID (m_tx_valid),
        .M_TX_READY (m_tx_ready),
        .M_TX_DATA  (m_tx_data),
        .S_RX_VALID (s_rx_valid),
        .S_RX_READY (s_rx_ready),
        .S_RX_DATA  (s_rx_data),
        .M_CH_VALID (m_ch_valid),
        .M_CH_READY (m_ch_ready),
        .M_CH_DATA  (m_ch_data),
        .o_rx_drop  (o_rx_drop),
        .o_tx_chan  (o_tx_chan)
    );

    // ---------------- bench state ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] src_q  [NCH][$];
    logic [6:0] exp_tx [NCH][$];
    logic [6:0] exp_rx [NCH][$];
    logic [7:0] rx_src_q [$];
    logic [7:0] out_log [$];
    logic [7:0] exp_log [$];

    int ann_ch         = -1;
    int m_rx_ch        = 0;
    bit m_rx_vld       = 1'b1;
    int exp_drops      = 0;
    int obs_drops      = 0;
    int obs_chv_cycles = 0;

    int unsigned tx_gap      = 0;
    int unsigned tx_rdy_pct  = 100;
    int unsigned rx_gap      = 0;
    int unsigned sink_pct    = 100;
    bit          tx_rdy_auto = 1'b1;
    bit          sink_auto   = 1'b1;

    logic [NCH-1:0] tx_hs_s = '0;
    logic           rx_hs_s = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic tx_send(input int k, input logic [6:0] b);
        src_q[k].push_back(b);
        exp_tx[k].push_back(b);
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_src_q.push_back(b);
        if (b[7]) begin
            if (b[6:4] == 3'b000 && int'(b[3:0]) < NCH) begin
                m_rx_ch  = int'(b[3:0]);
                m_rx_vld = 1'b1;
            end else begin
                m_rx_vld = 1'b0;
                exp_drops++;
            end
        end else if (m_rx_vld) begin
            exp_rx[m_rx_ch].push_back(b[6:0]);
        end else begin
            exp_drops++;
        end
    endtask

    task automatic tx_observe(input logic [7:0] b);
        out_log.push_back(b);
        if (b[7]) begin
            check("sel_fmt", 32'(b[6:4]), 0);
            check("sel_range", 32'(int'(b[3:0]) < NCH), 1);
            check("sel_redundant", 32'(ann_ch == int'(b[3:0])), 0);
            ann_ch = int'(b[3:0]);
        end else begin
            check("data_announced", 32'(ann_ch >= 0), 1);
            if (ann_ch >= 0) begin
                if (exp_tx[ann_ch].size() == 0)
                    check($sformatf("tx_unexpected_ch%0d", ann_ch), 32'(b), 32'hFFFF_FFFF);
                else
                    check($sformatf("tx_data_ch%0d", ann_ch), 32'(b), 32'(exp_tx[ann_ch].pop_front()));
            end
        end
    endtask

    task automatic rx_observe(input int k, input logic [6:0] d);
        if (exp_rx[k].size() == 0)
            check($sformatf("rx_unexpected_ch%0d", k), 32'(d), 32'hFFFF_FFFF);
        else
            check($sformatf("rx_data_ch%0d", k), 32'(d), 32'(exp_rx[k].pop_front()));
    endtask

    // ---------------- monitor (away from the active edge) ----------------
    always @(negedge clk) begin
        tx_hs_s = s_ch_valid & s_ch_ready;
        rx_hs_s = s_rx_valid & s_rx_ready;
        if (i_reset) begin
            ann_ch = -1;
        end else begin
            if (m_tx_valid && m_tx_ready)
                tx_observe(m_tx_data);
            if (o_rx_drop) begin
                obs_drops++;
                check("drop_on_handshake", 32'(rx_hs_s), 1);
            end
            if (m_ch_valid != '0) begin
                obs_chv_cycles++;
                check("ch_valid_onehot", 32'($onehot(m_ch_valid)), 1);
            end
            for (int k = 0; k < NCH; k++)
                if (m_ch_valid[k] && m_ch_ready[k])
                    rx_observe(k, m_ch_data);
        end
    end

    // ---------------- drivers ----------------
    initial begin
        s_ch_valid = '0;
        s_ch_data  = '0;
        m_tx_ready = 1'b0;
        s_rx_valid = 1'b0;
        s_rx_data  = 8'h00;
        m_ch_ready = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NCH; k++) begin
                if (tx_hs_s[k] && src_q[k].size() > 0)
                    void'(src_q[k].pop_front());
                if (src_q[k].size() > 0 && $urandom_range(99) >= tx_gap) begin
                    s_ch_valid[k]        = 1'b1;
                    s_ch_data[7*k +: 7]  = src_q[k][0];
                end else begin
                    s_ch_valid[k] = 1'b0;
                end
            end
            if (tx_rdy_auto)
                m_tx_ready = ($urandom_range(99) < tx_rdy_pct);
            if (rx_hs_s && rx_src_q.size() > 0)
                void'(rx_src_q.pop_front());
            if (rx_src_q.size() > 0 && $urandom_range(99) >= rx_gap) begin
                s_rx_valid = 1'b1;
                s_rx_data  = rx_src_q[0];
            end else begin
                s_rx_valid = 1'b0;
            end
            if (sink_auto)
                for (int k = 0; k < NCH; k++)
                    m_ch_ready[k] = ($urandom_range(99) < sink_pct);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_tx_drain(input string tag);
        int left;
        bit done;
        left = 3000;
        done = 1'b0;
        while (!done && left > 0) begin
            done = 1'b1;
            for (int k = 0; k < NCH; k++)
                if (src_q[k].size() != 0 || exp_tx[k].size() != 0) done = 1'b0;
            if (!done) begin
                step();
                left--;
            end
        end
        check({tag, "_tx_drain"}, 32'(done), 1);
        step();
    endtask

    task automatic wait_rx_drain(input string tag);
        int left;
        bit done;
        left = 3000;
        done = 1'b0;
        while (!done && left > 0) begin
            done = (rx_src_q.size() == 0);
            for (int k = 0; k < NCH; k++)
                if (exp_rx[k].size() != 0) done = 1'b0;
            if (!done) begin
                step();
                left--;
            end
        end
        check({tag, "_rx_drain"}, 32'(done), 1);
        step();
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 32'(out_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < out_log.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(out_log[i]), 32'(exp_log[i]));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [6:0] a0 [12];
        logic [6:0] a1 [12];
        logic [6:0] x;
        logic [6:0] y;
        logic [7:0] b;
        int         d0;
        int         e0;
        int         c0;
        int         left;

        i_reset = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("rst_tx_valid", 32'(m_tx_valid), 0);
        check("rst_ch_ready", 32'(s_ch_ready), 0);
        check("rst_ch_valid", 32'(m_ch_valid), 0);
        check("rst_rx_ready", 32'(s_rx_ready), 0);
        check("rst_rx_drop", 32'(o_rx_drop), 0);
        check("rst_tx_chan", 32'(o_tx_chan), 0);
        step();
        i_reset = 1'b0;
        @(negedge clk);
        check("idle_tx_valid", 32'(m_tx_valid), 0);
        check("idle_tx_chan", 32'(o_tx_chan), 0);
        step();

        // Lone client 2: select then data; second burst needs no select
        out_log.delete();
        tx_send(2, 7'h11); tx_send(2, 7'h22); tx_send(2, 7'h33);
        wait_tx_drain("c2_first");
        exp_log = '{8'h82, 8'h11, 8'h22, 8'h33};
        check_log("c2_first");
        out_log.delete();
        tx_send(2, 7'h44); tx_send(2, 7'h55);
        wait_tx_drain("c2_again");
        exp_log = '{8'h44, 8'h55};
        check_log("c2_again");

        // Clients 0 and 1 compete: alternating bursts of MAXBURST
        out_log.delete();
        for (int i = 0; i < 12; i++) begin
            a0[i] = 7'($urandom_range(127));
            a1[i] = 7'($urandom_range(127));
            tx_send(0, a0[i]);
            tx_send(1, a1[i]);
        end
        wait_tx_drain("rr");
        exp_log.delete();
        for (int r = 0; r < 3; r++) begin
            exp_log.push_back(8'h80);
            for (int i = 0; i < MAXBURST; i++) exp_log.push_back({1'b0, a0[r*MAXBURST+i]});
            exp_log.push_back(8'h81);
            for (int i = 0; i < MAXBURST; i++) exp_log.push_back({1'b0, a1[r*MAXBURST+i]});
        end
        check_log("rr");

        // Host stalls the select byte for client 1
        out_log.delete();
        x = 7'($urandom_range(127));
        y = 7'($urandom_range(127));
        tx_send(0, x);
        wait_tx_drain("pre_stall");
        tx_rdy_auto = 1'b0;
        m_tx_ready  = 1'b0;
        tx_send(1, y);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(m_tx_valid), 1);
            check("stall_data", 32'(m_tx_data), 32'h81);
            check("stall_ch_ready", 32'(s_ch_ready), 0);
        end
        step();
        m_tx_ready  = 1'b1;
        tx_rdy_auto = 1'b1;
        wait_tx_drain("stall");
        exp_log = '{8'h80, {1'b0, x}, 8'h81, {1'b0, y}};
        check_log("stall");

        // RX routing with a back-pressuring client 3; leading byte goes to channel 0
        sink_auto  = 1'b0;
        m_ch_ready = 4'b0111;
        rx_send(8'h05); rx_send(8'h83); rx_send(8'h41); rx_send(8'h80); rx_send(8'h42);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rx_stall_ready", 32'(s_rx_ready), 0);
            check("rx_stall_valid", 32'(m_ch_valid), 32'h8);
            check("rx_stall_data", 32'(m_ch_data), 32'h41);
        end
        step();
        m_ch_ready = '1;
        sink_auto  = 1'b1;
        wait_rx_drain("rx_route");

        // Bad select, then an orphaned data byte
        d0 = obs_drops;
        e0 = exp_drops;
        c0 = obs_chv_cycles;
        rx_send(8'h9F); rx_send(8'h10);
        wait_rx_drain("rx_drop");
        check("rx_drop_count", 32'(obs_drops - d0), 32'(exp_drops - e0));
        check("rx_drop_no_valid", 32'(obs_chv_cycles - c0), 0);

        // Reset in the middle of a client 1 burst
        out_log.delete();
        for (int i = 0; i < 8; i++) tx_send(1, 7'($urandom_range(127)));
        left = 200;
        while (out_log.size() < 2 && left > 0) begin
            step();
            left--;
        end
        check("mid_burst_reached", 32'(out_log.size() >= 2), 1);
        i_reset = 1'b1;
        m_rx_ch  = 0;
        m_rx_vld = 1'b1;
        step();
        i_reset = 1'b0;
        out_log.delete();
        wait_tx_drain("post_reset");
        check("post_reset_len", 32'(out_log.size() > 0), 1);
        if (out_log.size() > 0)
            check("post_reset_sel", 32'(out_log[0]), 32'h81);

        // Randomized traffic on both paths
        tx_gap     = 20;
        tx_rdy_pct = 70;
        rx_gap     = 20;
        sink_pct   = 60;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NCH; k++) begin
                int n;
                n = int'($urandom_range(10));
                for (int i = 0; i < n; i++) tx_send(k, 7'($urandom_range(127)));
            end
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(99) < 25) begin
                    b = 8'h80 | 8'($urandom_range(5));
                    if ($urandom_range(9) == 0) b = b | 8'h30;
                end else begin
                    b = {1'b0, 7'($urandom_range(127))};
                end
                rx_send(b);
            end
            wait_tx_drain($sformatf("rand%0d", r));
            wait_rx_drain($sformatf("rand%0d", r));
            check($sformatf("rand%0d_drops", r), 32'(obs_drops), 32'(exp_drops));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
